// File: rtl/backprop_train_seq.sv
// backprop_train_seq: per-sample forward/backprop/weight-write sequencer with epoch looping and handshake watchdog.
// Optional feature: define TRAIN_EARLY_STOP_EN to end a run early once an epoch's errors are all below ERR_THRESH.
module backprop_train_seq #(
    parameter int NUM_W      = 4,
    parameter int SAMPLE_W   = 4,
    parameter int EPOCH_W    = 8,
    parameter int TIMEOUT    = 255,
    parameter int ERR_W      = 23,
    parameter int ERR_THRESH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     zero_weight_reset_i,
    input  logic [SAMPLE_W-1:0]      n_samples_i,
    input  logic [EPOCH_W-1:0]       n_epochs_i,
    output logic                     fwd_start_o,
    input  logic                     fwd_done_i,
    input  logic [ERR_W-1:0]         err_mag_i,
    output logic                     bp_en_o,
    input  logic                     b_end_i,
    output logic                     wr_en_o,
    output logic [$clog2(NUM_W)-1:0] wr_addr_o,
    output logic [SAMPLE_W-1:0]      sample_o,
    output logic [EPOCH_W-1:0]       epoch_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     converged_o
);
    localparam int AW   = $clog2(NUM_W);
    localparam int WD_W = $clog2(TIMEOUT + 1);
`ifdef TRAIN_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FWD_REQ, FWD_WAIT, BWD, BWD_WAIT, WRITE, NEXT, DONE} state_t;

    state_t              r_state, w_state;
    logic [SAMPLE_W-1:0] r_ns, w_ns, r_sample, w_sample;
    logic [EPOCH_W-1:0]  r_ne, w_ne, r_epoch, w_epoch;
    logic [WD_W-1:0]     r_wd, w_wd;
    logic [AW-1:0]       r_widx, w_widx;
    logic                r_timeout, w_timeout, r_conv, w_conv, r_flag, w_flag;

    // State and counter registers; everything clears on async reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_ns      <= '0;
            r_ne      <= '0;
            r_sample  <= '0;
            r_epoch   <= '0;
            r_wd      <= '0;
            r_widx    <= '0;
            r_timeout <= 1'b0;
            r_conv    <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ns      <= w_ns;
            r_ne      <= w_ne;
            r_sample  <= w_sample;
            r_epoch   <= w_epoch;
            r_wd      <= w_wd;
            r_widx    <= w_widx;
            r_timeout <= w_timeout;
            r_conv    <= w_conv;
            r_flag    <= w_flag;
        end
    end

    // Next-state and counter updates; the abort input overrides every transition but keeps sticky flags
    always_comb begin
        w_state   = r_state;
        w_ns      = r_ns;
        w_ne      = r_ne;
        w_sample  = r_sample;
        w_epoch   = r_epoch;
        w_wd      = r_wd;
        w_widx    = r_widx;
        w_timeout = r_timeout;
        w_conv    = r_conv;
        w_flag    = r_flag;
        case (r_state)
            IDLE: if (start_i) begin
                w_ns      = n_samples_i;
                w_ne      = n_epochs_i;
                w_sample  = '0;
                w_epoch   = '0;
                w_timeout = 1'b0;
                w_conv    = 1'b0;
                w_state   = (n_samples_i == '0 || n_epochs_i == '0) ? DONE : FWD_REQ;
            end
            FWD_REQ: begin
                w_wd    = '0;
                w_state = FWD_WAIT;
                if (EARLY && r_sample == '0) w_flag = 1'b1;
            end
            FWD_WAIT: if (fwd_done_i) begin
                w_state = BWD;
                if (EARLY && err_mag_i >= ERR_W'(ERR_THRESH)) w_flag = 1'b0;
            end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                w_state   = DONE;
                w_timeout = 1'b1;
            end else begin
                w_wd = r_wd + 1'b1;
            end
            BWD: begin
                w_wd    = '0;
                w_state = BWD_WAIT;
            end
            BWD_WAIT: if (b_end_i) begin
                w_state = WRITE;
            end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                w_state   = DONE;
                w_timeout = 1'b1;
            end else begin
                w_wd = r_wd + 1'b1;
            end
            WRITE: begin
                w_widx  = (r_widx == AW'(NUM_W - 1)) ? '0 : r_widx + 1'b1;
                w_state = (r_widx == AW'(NUM_W - 1)) ? NEXT : WRITE;
            end
            NEXT: if (r_sample == r_ns - 1'b1) begin
                w_sample = '0;
                if (r_epoch == r_ne - 1'b1 || r_flag) begin
                    w_state = DONE;
                    w_conv  = r_flag;
                end else begin
                    w_epoch = r_epoch + 1'b1;
                    w_state = FWD_REQ;
                end
            end else begin
                w_sample = r_sample + 1'b1;
                w_state  = FWD_REQ;
            end
            default: w_state = IDLE;
        endcase
        if (zero_weight_reset_i) begin
            w_state   = IDLE;
            w_sample  = '0;
            w_epoch   = '0;
            w_wd      = '0;
            w_widx    = '0;
            w_flag    = 1'b0;
            w_timeout = r_timeout;
            w_conv    = r_conv;
        end
    end

    assign fwd_start_o = (r_state == FWD_REQ);
    assign bp_en_o     = (r_state == BWD);
    assign wr_en_o     = (r_state == WRITE);
    assign wr_addr_o   = r_widx;
    assign sample_o    = r_sample;
    assign epoch_o     = r_epoch;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign timeout_o   = r_timeout;
    assign converged_o = r_conv;
endmodule

// File: tb/tb_backprop_train_seq.sv
// tb_backprop_train_seq: scoreboard bench for backprop_train_seq with a randomized handshake responder.
module tb_backprop_train_seq;
    localparam int ERR_THRESH = 4;
`ifdef TRAIN_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [1:0] K_FWD = 2'd0, K_BP = 2'd1, K_WR = 2'd2, K_DN = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] addr;
        logic [3:0] s;
        logic [7:0] e;
        logic       to;
        logic       cv;
    } ev_t;

    logic        clk = 1'b0, rst_i = 1'b0, start_i = 1'b0, zero_weight_reset_i = 1'b0;
    logic        fwd_done_i = 1'b0, b_end_i = 1'b0;
    logic [3:0]  n_samples_i = '0;
    logic [7:0]  n_epochs_i = '0;
    logic [22:0] err_mag_i = '0;
    logic        fwd_start_o, bp_en_o, wr_en_o, busy_o, done_o, timeout_o, converged_o;
    logic [1:0]  wr_addr_o;
    logic [3:0]  sample_o;
    logic [7:0]  epoch_o;

    ev_t sb[$];
    int  errs[256];
    int  checks = 0, errors = 0;
    int  n_fwd = 0, n_bp = 0, n_wr = 0;
    bit  resp_on = 1'b1;
    int  force_fd = -1, force_bd = -1;

    backprop_train_seq dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .zero_weight_reset_i(zero_weight_reset_i),
        .n_samples_i(n_samples_i), .n_epochs_i(n_epochs_i), .fwd_start_o(fwd_start_o),
        .fwd_done_i(fwd_done_i), .err_mag_i(err_mag_i), .bp_en_o(bp_en_o), .b_end_i(b_end_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .sample_o(sample_o), .epoch_o(epoch_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .converged_o(converged_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic ev_t ev(input logic [1:0] kind, input int a, input int s, input int e,
                               input logic to, input logic cv);
        ev_t r;
        r.kind = kind; r.addr = 2'(a); r.s = 4'(s); r.e = 8'(e); r.to = to; r.cv = cv;
        return r;
    endfunction

    // Reference: the run as a flat list of strobes, derived from the loop structure of training
    task automatic model(input int ns, input int ne, input bit to_exp);
        int  k = 0;
        bit  flag;
        if (to_exp) begin
            sb.push_back(ev(K_FWD, 0, 0, 0, 0, 0));
            sb.push_back(ev(K_DN, 0, 0, 0, 1, 0));
            return;
        end
        if (ns == 0 || ne == 0) begin
            sb.push_back(ev(K_DN, 0, 0, 0, 0, 0));
            return;
        end
        for (int e = 0; e < ne; e++) begin
            flag = 1'b1;
            for (int s = 0; s < ns; s++) begin
                sb.push_back(ev(K_FWD, 0, s, e, 0, 0));
                if (errs[k] >= ERR_THRESH) flag = 1'b0;
                k++;
                sb.push_back(ev(K_BP, 0, s, e, 0, 0));
                for (int a = 0; a < 4; a++) sb.push_back(ev(K_WR, a, s, e, 0, 0));
            end
            if (EARLY && flag) begin
                sb.push_back(ev(K_DN, 0, 0, e, 0, 1));
                return;
            end
        end
        sb.push_back(ev(K_DN, 0, 0, ne - 1, 0, 0));
    endtask

    // Monitor: every strobe the DUT presents is popped from the scoreboard and compared
    initial forever begin
        @(negedge clk);
        if (rst_i && (fwd_start_o || bp_en_o || wr_en_o || done_o)) begin
            ev_t act, exp;
            act.kind = fwd_start_o ? K_FWD : bp_en_o ? K_BP : wr_en_o ? K_WR : K_DN;
            act.addr = wr_addr_o; act.s = sample_o; act.e = epoch_o; act.to = timeout_o; act.cv = converged_o;
            n_fwd += int'(fwd_start_o);
            n_bp  += int'(bp_en_o);
            n_wr  += int'(wr_en_o);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual=%h required=none", act);
            end else begin
                exp = sb.pop_front();
                chk("event", act, exp);
            end
        end
    end

    // Responder: answers fwd_start/bp_en after a delay, with spurious opposite-handshake noise while waiting
    initial begin
        int  f_cd = 0, b_cd = 0, k = 0;
        bit  f_act = 0, b_act = 0;
        forever begin
            @(negedge clk);
            fwd_done_i = 1'b0;
            b_end_i    = 1'b0;
            if (!busy_o) begin
                f_act = 0; b_act = 0; k = 0;
            end else if (fwd_start_o) begin
                f_act = resp_on;
                f_cd  = force_fd >= 0 ? force_fd : int'($urandom_range(0, 4));
            end else if (bp_en_o) begin
                b_act = resp_on;
                b_cd  = force_bd >= 0 ? force_bd : int'($urandom_range(0, 4));
            end else if (f_act) begin
                if (f_cd == 0) begin
                    fwd_done_i = 1'b1;
                    err_mag_i  = 23'(errs[k]);
                    k++;
                    f_act = 0;
                end else begin
                    f_cd--;
                    b_end_i = 1'($urandom_range(0, 1));
                end
            end else if (b_act) begin
                if (b_cd == 0) begin
                    b_end_i = 1'b1;
                    b_act = 0;
                end else begin
                    b_cd--;
                    fwd_done_i = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic run(input int ns, input int ne, input bit noise, input int mode, input bit to_exp, output int lat);
        int n = 0;
        for (int i = 0; i < 256; i++)
            errs[i] = mode == 1 ? 2 : mode == 2 ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 9));
        model(ns, ne, to_exp);
        @(negedge clk);
        n_samples_i = 4'(ns); n_epochs_i = 8'(ne); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        while (!done_o && n < 5000) begin
            @(negedge clk);
            n++;
            if (noise) begin
                start_i     = ($urandom_range(0, 7) == 0);
                n_samples_i = 4'($urandom);
                n_epochs_i  = 8'($urandom);
            end
        end
        start_i = 1'b0;
        lat = n;
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL run_budget actual=no_done required=done");
        end
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int lat, f0, b0, w0, n;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {fwd_start_o, bp_en_o, wr_en_o, wr_addr_o, sample_o, epoch_o,
                              busy_o, done_o, timeout_o, converged_o}, 0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);

        force_fd = 2; force_bd = 1;
        f0 = n_fwd; b0 = n_bp; w0 = n_wr;
        run(2, 3, 0, 0, 0, lat);
        chk("fwd_count", n_fwd - f0, 6);
        chk("bp_count", n_bp - b0, 6);
        chk("wr_count", n_wr - w0, 24);
        chk("final_epoch", epoch_o, 2);
        chk("final_sample", sample_o, 0);
        force_fd = -1; force_bd = -1;

        run(0, 5, 0, 0, 0, lat);
        chk("zero_samples_latency", lat, 0);
        run(3, 0, 0, 0, 0, lat);
        chk("zero_epochs_latency", lat, 0);

        resp_on = 1'b0;
        run(1, 1, 0, 0, 1, lat);
        chk("timeout_latency", lat, 256);
        chk("timeout_sticky", timeout_o, 1);
        resp_on = 1'b1;
        @(negedge clk); zero_weight_reset_i = 1'b1;
        @(negedge clk); zero_weight_reset_i = 1'b0;
        chk("sticky_kept_on_abort", timeout_o, 1);

        force_fd = 254;
        run(1, 1, 0, 0, 0, lat);
        chk("handshake_beats_timeout", timeout_o, 0);
        force_fd = -1;

        force_bd = 30;
        sb.push_back(ev(K_FWD, 0, 0, 0, 0, 0));
        sb.push_back(ev(K_BP, 0, 0, 0, 0, 0));
        @(negedge clk);
        n_samples_i = 4'd3; n_epochs_i = 8'd2; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!bp_en_o && n < 200) begin
            @(negedge clk);
            n++;
            start_i = (n == 2);
        end
        start_i = 1'b0;
        chk("reach_bwd", bp_en_o, 1);
        repeat (2) @(negedge clk);
        zero_weight_reset_i = 1'b1;
        @(negedge clk);
        zero_weight_reset_i = 1'b0;
        chk("abort_idle", {busy_o, done_o, wr_en_o, sample_o, epoch_o}, 0);
        repeat (20) @(negedge clk);
        chk("abort_quiet", sb.size(), 0);
        force_bd = -1;

        run(3, 10, 0, 1, 0, lat);
        chk("early_converged", converged_o, EARLY);
        chk("early_epoch", epoch_o, EARLY ? 0 : 9);

        for (int i = 0; i < 8; i++)
            run(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1, int'($urandom_range(0, 2)), 0, lat);

        model(2, 2, 0);
        @(negedge clk);
        n_samples_i = 4'd2; n_epochs_i = 8'd2; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!wr_en_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_write", wr_en_o, 1);
        #2 rst_i = 1'b0;
        #1;
        chk("async_reset_outputs", {fwd_start_o, bp_en_o, wr_en_o, wr_addr_o, sample_o, epoch_o,
                                    busy_o, done_o, timeout_o, converged_o}, 0);
        sb.delete();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("busy_after_release", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
